// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory port of the load/store unit.
// Request : req_valid, req_ready, req_store, req_size, req_unsigned, req_addr, req_wdata
// Response: resp_valid, resp_err, resp_rdata
// Memory  : mem_a, mem_we, mem_wd (word writes), mem_rd (combinational read data for mem_a)
// slave is the unit itself; master is the CPU datapath together with the data memory.
interface load_store_unit_if;
   logic        req_valid, req_ready, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we;
   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_a, mem_we, mem_wd
   );
   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_a, mem_we, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: big-endian byte/half/word load-store sequencer over a word-wide async-read memory.
// clk     : rising-edge clock
// reset_n : synchronous active-low reset
// bus     : load_store_unit_if.slave (request handshake, one-cycle response, word memory port)
// Sub-word stores are done as read-modify-write so memory only ever sees whole-word writes.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input logic              clk,
   input logic              reset_n,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;
   state_t      state;
   logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
   logic [1:0]  size_q;
   logic        store_q, unsigned_q, err_q, ready_q, valid_q;
   logic        bad, sgn, wr;
   logic [4:0]  rsh;
   logic [31:0] lane, ext, mask, ins;
   always_comb begin
      bad  = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
             (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
             bus.req_size == 2'b11 ||
             {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
      // distance of the addressed lane from bit 0 (big-endian: offset 0 is the top lane)
      rsh  = size_q == 2'b00 ? {~addr_q[1:0], 3'b000} :
             size_q == 2'b01 ? {~addr_q[1], 4'b0000} : 5'd0;
      lane = bus.mem_rd >> rsh;
      sgn  = ~unsigned_q & (size_q == 2'b00 ? lane[7] : lane[15]);
      ext  = size_q == 2'b00 ? {{24{sgn}}, lane[7:0]} :
             size_q == 2'b01 ? {{16{sgn}}, lane[15:0]} : lane;
      mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << rsh;
      ins  = (size_q == 2'b00 ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]}) << rsh;
      wr   = state == WRITE && store_q;
   end
   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = valid_q;
   assign bus.resp_err   = err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.mem_a      = (state == LOAD || state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
   // gated by reset_n so an aborting reset edge can never land a write
   assign bus.mem_we     = wr && reset_n;
   assign bus.mem_wd     = wr ? (size_q == 2'b10 ? wdata_q : (merge_q & ~mask) | ins) : '0;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
         size_q     <= '0;
         store_q    <= 1'b0;
         unsigned_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               addr_q     <= bus.req_addr;
               wdata_q    <= bus.req_wdata;
               size_q     <= bus.req_size;
               store_q    <= bus.req_store;
               unsigned_q <= bus.req_unsigned;
               err_q      <= bad;
               valid_q    <= bad;
               ready_q    <= 1'b0;
               state      <= bad ? RESP : !bus.req_store ? LOAD : bus.req_size == 2'b10 ? WRITE : READ;
            end
            LOAD: begin
               rdata_q <= ext;
               valid_q <= 1'b1;
               state   <= RESP;
            end
            READ: begin
               merge_q <= bus.mem_rd;
               state   <= WRITE;
            end
            WRITE: begin
               valid_q <= 1'b1;
               state   <= RESP;
            end
            RESP: begin
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level reference model.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_pass = 0, n_total = 0;
   load_store_unit_if bus();
   load_store_unit #(.MEM_WORDS(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;

   // data memory seen by the DUT
   logic [31:0] mem [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   assign bus.mem_rd = mem[bus.mem_a[7:2]];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
      else if (pl_en) mem[pl_idx] <= pl_val;
   end

   // reference memory: what every word should hold
   logic [31:0] ref_mem [64];

   typedef struct {
      logic st; logic [1:0] sz; logic un; logic [31:0] a, wd, pre, exp_rd, exp_wd; int lat, wecyc;
   } case_t;

   task automatic preload(input int idx, input logic [31:0] val);
      pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
      @(posedge clk);
      #1 pl_en = 1'b0;
      @(negedge clk);
      ref_mem[idx] = val;
   endtask

   // byte-level model: big-endian lanes, sign/zero extension, per-byte store update
   task automatic model_req(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                            input logic [31:0] wd, output logic e, output logic [31:0] rd, output int lat);
      int n, off, sh;
      logic [31:0] w, v;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e = (sz == 2'd3) || (a % n != 0) || (a / 4 >= 64);
      rd = '0;
      lat = e ? 1 : (!st || sz == 2'd2) ? 2 : 3;
      if (!e) begin
         w = ref_mem[a[7:2]]; off = int'(a % 4); v = '0;
         for (int i = 0; i < n; i++) begin
            sh = 8 * (3 - (off + i));
            if (st) w = (w & ~(32'hFF << sh)) | (((wd >> (8 * (n - 1 - i))) & 32'hFF) << sh);
            else v = (v << 8) | ((w >> sh) & 32'hFF);
         end
         if (st) ref_mem[a[7:2]] = w;
         else begin
            if (!un && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
         end
      end
   endtask

   // drives one request from a negedge and watches until its response (bounded)
   task automatic issue(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic e, output logic [31:0] rd,
                        output int nwe, output int wecyc, output logic [31:0] wd_seen);
      lat = -1; e = 1'b0; rd = '0; nwe = 0; wecyc = -1; wd_seen = '0;
      for (int k = 0; k < 10 && !bus.req_ready; k++) @(negedge clk);
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz; bus.req_unsigned = un;
      bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (bus.mem_we) begin nwe++; wecyc = c; wd_seen = bus.mem_wd; end
         if (bus.resp_valid) begin lat = c; e = bus.resp_err; rd = bus.resp_rdata; break; end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else n_pass++;
      n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else n_pass++;
      n_total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); else n_pass++;
      n_total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); else n_pass++;
      n_total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); else n_pass++;
      n_total++; if (bus.mem_a !== 32'h0) $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); else n_pass++;
      n_total++; if (bus.mem_wd !== 32'h0) $display("FAIL reset_mem_wd: got %h want 0", bus.mem_wd); else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loads();
      case_t t [6];
      int lat, nwe, wc; logic e; logic [31:0] rd, ws, mrd; logic me;
      t[0] = '{1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, 32'h0, 32'hFFFF_FF88, 32'h0, 2, -1};
      t[1] = '{1'b0, 2'd0, 1'b1, 32'h0F, 32'h0, 32'h0, 32'h0000_00BB, 32'h0, 2, -1};
      t[2] = '{1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 32'h0, 32'hFFFF_AABB, 32'h0, 2, -1};
      t[3] = '{1'b0, 2'd1, 1'b1, 32'h0C, 32'h0, 32'h0, 32'h0000_8899, 32'h0, 2, -1};
      t[4] = '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'h0, 32'h8899_AABB, 32'h0, 2, -1};
      t[5] = '{1'b0, 2'd0, 1'b0, 32'h0E, 32'h0, 32'h0, 32'hFFFF_FFAA, 32'h0, 2, -1};
      preload(3, 32'h8899_AABB);
      foreach (t[i]) begin
         model_req(t[i].st, t[i].sz, t[i].un, t[i].a, t[i].wd, me, mrd, lat);
         issue(t[i].st, t[i].sz, t[i].un, t[i].a, t[i].wd, lat, e, rd, nwe, wc, ws);
         n_total++; if (rd !== t[i].exp_rd) $display("FAIL load%0d_rdata: got %h want %h", i, rd, t[i].exp_rd); else n_pass++;
         n_total++; if (rd !== mrd) $display("FAIL load%0d_model: got %h want %h", i, rd, mrd); else n_pass++;
         n_total++; if (lat !== t[i].lat) $display("FAIL load%0d_latency: got %0d want %0d", i, lat, t[i].lat); else n_pass++;
         n_total++; if (e !== 1'b0 || nwe !== 0) $display("FAIL load%0d_err_we: got err=%b we=%0d want 0/0", i, e, nwe); else n_pass++;
      end
   endtask

   task automatic test_stores();
      case_t t [5];
      int lat, nwe, wc; logic e; logic [31:0] rd, ws, mrd; logic me;
      t[0] = '{1'b1, 2'd0, 1'b0, 32'h15, 32'hEE,        32'h1122_3344, 32'h0,         32'h11EE_3344, 3, 2};
      t[1] = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,         32'h1122_3344, 32'h11EE_3344, 32'h11EE_3344, 2, -1};
      t[2] = '{1'b1, 2'd1, 1'b0, 32'h16, 32'hCAFE,      32'h1122_3344, 32'h0,         32'h1122_CAFE, 3, 2};
      t[3] = '{1'b1, 2'd2, 1'b0, 32'h00, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'hDEAD_BEEF, 2, 1};
      t[4] = '{1'b1, 2'd0, 1'b0, 32'h1C, 32'h1234_5677, 32'hAABB_CCDD, 32'h0,         32'h77BB_CCDD, 3, 2};
      foreach (t[i]) begin
         if (i != 1) preload(int'(t[i].a[7:2]), t[i].pre);
         model_req(t[i].st, t[i].sz, t[i].un, t[i].a, t[i].wd, me, mrd, lat);
         issue(t[i].st, t[i].sz, t[i].un, t[i].a, t[i].wd, lat, e, rd, nwe, wc, ws);
         n_total++; if (lat !== t[i].lat || e !== 1'b0) $display("FAIL st%0d_latency: got %0d err=%b want %0d err=0", i, lat, e, t[i].lat); else n_pass++;
         n_total++; if (rd !== t[i].exp_rd) $display("FAIL st%0d_rdata: got %h want %h", i, rd, t[i].exp_rd); else n_pass++;
         n_total++; if (nwe !== (t[i].st ? 1 : 0) || wc !== t[i].wecyc) $display("FAIL st%0d_we: got %0d pulses at %0d want %0d at %0d", i, nwe, wc, t[i].st ? 1 : 0, t[i].wecyc); else n_pass++;
         if (t[i].st) begin
            n_total++; if (ws !== t[i].exp_wd) $display("FAIL st%0d_mem_wd: got %h want %h", i, ws, t[i].exp_wd); else n_pass++;
         end
         n_total++; if (mem[t[i].a[7:2]] !== t[i].exp_wd) $display("FAIL st%0d_mem_word: got %h want %h", i, mem[t[i].a[7:2]], t[i].exp_wd); else n_pass++;
      end
   endtask

   task automatic test_errors();
      case_t t [6];
      int lat, nwe, wc; logic e; logic [31:0] rd, ws, mrd; logic me;
      t[0] = '{1'b0, 2'd1, 1'b0, 32'h01,  32'h0,         32'h0, 32'h0, 32'h0, 1, -1};
      t[1] = '{1'b1, 2'd2, 1'b0, 32'h02,  32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1, -1};
      t[2] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'h0, 32'h0, 32'h0, 1, -1};
      t[3] = '{1'b0, 2'd3, 1'b0, 32'h04,  32'h0,         32'h0, 32'h0, 32'h0, 1, -1};
      t[4] = '{1'b1, 2'd1, 1'b0, 32'h03,  32'hFFFF,      32'h0, 32'h0, 32'h0, 1, -1};
      t[5] = '{1'b1, 2'd0, 1'b0, 32'h104, 32'hFF,        32'h0, 32'h0, 32'h0, 1, -1};
      foreach (t[i]) begin
         model_req(t[i].st, t[i].sz, t[i].un, t[i].a, t[i].wd, me, mrd, lat);
         issue(t[i].st, t[i].sz, t[i].un, t[i].a, t[i].wd, lat, e, rd, nwe, wc, ws);
         n_total++; if (e !== 1'b1 || me !== 1'b1) $display("FAIL err%0d_flag: got %b model %b want 1", i, e, me); else n_pass++;
         n_total++; if (lat !== 1) $display("FAIL err%0d_latency: got %0d want 1", i, lat); else n_pass++;
         n_total++; if (rd !== 32'h0) $display("FAIL err%0d_rdata: got %h want 0", i, rd); else n_pass++;
         n_total++; if (nwe !== 0) $display("FAIL err%0d_mem_we: got %0d pulses want 0", i, nwe); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int got; logic [31:0] r;
      got = -1; r = '0;
      preload(8, 32'h0); preload(9, 32'h0102_0304); preload(10, 32'h77);
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h21; bus.req_wdata = 32'h5A;
      @(posedge clk);
      for (int c = 1; c <= 3; c++) begin
         #1 bus.req_store = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h28; bus.req_wdata = 32'hBAD0_0000 | c;
         @(negedge clk);
         n_total++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_busy_ready c%0d: got %b want 0", c, bus.req_ready); else n_pass++;
         n_total++; if (bus.resp_valid !== (c == 3)) $display("FAIL b2b_resp c%0d: got %b want %b", c, bus.resp_valid, c == 3); else n_pass++;
         @(posedge clk);
      end
      #1 bus.req_store = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b1; bus.req_addr = 32'h26;
      @(negedge clk);
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_after_resp: got %b want 1", bus.req_ready); else n_pass++;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (bus.resp_valid) begin got = c; r = bus.resp_rdata; break; end
      end
      n_total++; if (got !== 2) $display("FAIL b2b_second_latency: got %0d want 2", got); else n_pass++;
      n_total++; if (r !== 32'h03) $display("FAIL b2b_second_rdata: got %h want 00000003", r); else n_pass++;
      n_total++; if (mem[8] !== 32'h005A_0000) $display("FAIL b2b_store_word: got %h want 005a0000", mem[8]); else n_pass++;
      n_total++; if (mem[10] !== 32'h77) $display("FAIL b2b_ignored_word: got %h want 00000077", mem[10]); else n_pass++;
      ref_mem[8] = 32'h005A_0000;
   endtask

   task automatic test_reset_mid_write();
      int seen;
      seen = 0;
      preload(12, 32'hA1B2_C3D4);
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h31; bus.req_wdata = 32'hEE;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.mem_we !== 1'b1) $display("FAIL rst_mid_in_write: got %b want 1", bus.mem_we); else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mid_we_gated: got %b want 0", bus.mem_we); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready); else n_pass++;
      n_total++; if (mem[12] !== 32'hA1B2_C3D4) $display("FAIL rst_mid_mem: got %h want a1b2c3d4", mem[12]); else n_pass++;
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (bus.resp_valid) seen++;
         @(negedge clk);
      end
      n_total++; if (seen !== 0) $display("FAIL rst_mid_no_resp: got %0d responses want 0", seen); else n_pass++;
   endtask

   task automatic test_random();
      int lat, mlat, nwe, wc, r; logic e, me; logic [31:0] rd, mrd, ws, a, wd; logic st, un; logic [1:0] sz;
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      for (int i = 0; i < 80; i++) begin
         r  = $urandom_range(0, 9);
         sz = r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
         a  = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         st = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1)); wd = $urandom;
         model_req(st, sz, un, a, wd, me, mrd, mlat);
         issue(st, sz, un, a, wd, lat, e, rd, nwe, wc, ws);
         n_total++; if (e !== me || lat !== mlat) $display("FAIL rnd%0d_err_lat: got err=%b lat=%0d want err=%b lat=%0d", i, e, lat, me, mlat); else n_pass++;
         n_total++; if (rd !== mrd) $display("FAIL rnd%0d_rdata: got %h want %h (a=%h sz=%0d un=%b)", i, rd, mrd, a, sz, un); else n_pass++;
         n_total++; if (nwe !== ((st && !me) ? 1 : 0)) $display("FAIL rnd%0d_we_count: got %0d want %0d", i, nwe, (st && !me) ? 1 : 0); else n_pass++;
         if (st && !me) begin
            n_total++; if (mem[a[7:2]] !== ref_mem[a[7:2]]) $display("FAIL rnd%0d_mem: got %h want %h", i, mem[a[7:2]], ref_mem[a[7:2]]); else n_pass++;
         end
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
